// File: rtl/t08_lcd_pkg.sv
// Shared types and constants for the LCD command sequencer: FSM states,
// panel opcodes, fixed init parameters and per-sequence step counts.
package t08_lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_CMD = 3'd1,
      ST_SEND_PAR = 3'd2,
      ST_WAIT_HI  = 3'd3,
      ST_WAIT_LO  = 3'd4,
      ST_NEXT     = 3'd5,
      ST_FINISH   = 3'd6
   } state_e;

   typedef enum logic {
      SEQ_INIT = 1'b0,
      SEQ_DRAW = 1'b1
   } seq_e;

   typedef struct packed {
      logic [15:0] x_start;
      logic [15:0] x_end;
      logic [15:0] y_start;
      logic [15:0] y_end;
      logic [15:0] pixel;
   } window_t;

   localparam logic [7:0] CMD_SWRESET = 8'h01;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;
   localparam logic [7:0] CMD_MADCTL  = 8'h36;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_CASET   = 8'h2A;
   localparam logic [7:0] CMD_PASET   = 8'h2B;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;

   localparam logic [7:0] INIT_COLMOD_PAR = 8'h55;
   localparam logic [7:0] INIT_MADCTL_PAR = 8'h48;

   localparam int unsigned INIT_LEN = 5;
   localparam int unsigned DRAW_LEN = 3;
   localparam logic [2:0] INIT_LAST_STEP = 3'(INIT_LEN - 1);
   localparam logic [2:0] DRAW_LAST_STEP = 3'(DRAW_LEN - 1);

   // Cycles spent in WAIT_HI before giving up on a busy acknowledge.
   localparam logic [7:0] WAIT_HI_LAST = 8'd254;

   function automatic logic [31:0] cmd_word(input logic [7:0] cmd, input logic [3:0] nparams);
      return {20'h0, nparams, cmd};
   endfunction

   function automatic logic [2:0] last_step(input seq_e seq);
      return (seq == SEQ_INIT) ? INIT_LAST_STEP : DRAW_LAST_STEP;
   endfunction

endpackage

// File: rtl/t08_lcd_step_rom.sv
// Combinational step table: (sequence, step, latched operands) to the command
// opcode, its parameter count and the MSB-first packed parameter word.
module t08_lcd_step_rom
   import t08_lcd_pkg::*;
(
   input  seq_e        seq_i,
   input  logic [2:0]  step_i,
   input  window_t     win_i,
   output logic [7:0]  cmd_o,
   output logic [3:0]  nparams_o,
   output logic [31:0] par_word_o
);

   always_comb begin
      cmd_o      = 8'h00;
      nparams_o  = 4'd0;
      par_word_o = 32'h0;
      if (seq_i == SEQ_INIT) begin
         case (step_i)
            3'd0: cmd_o = CMD_SWRESET;
            3'd1: cmd_o = CMD_SLPOUT;
            3'd2: begin
               cmd_o      = CMD_COLMOD;
               nparams_o  = 4'd1;
               par_word_o = {INIT_COLMOD_PAR, 24'h0};
            end
            3'd3: begin
               cmd_o      = CMD_MADCTL;
               nparams_o  = 4'd1;
               par_word_o = {INIT_MADCTL_PAR, 24'h0};
            end
            3'd4: cmd_o = CMD_DISPON;
            default: cmd_o = 8'h00;
         endcase
      end else begin
         case (step_i)
            3'd0: begin
               cmd_o      = CMD_CASET;
               nparams_o  = 4'd4;
               par_word_o = {win_i.x_start, win_i.x_end};
            end
            3'd1: begin
               cmd_o      = CMD_PASET;
               nparams_o  = 4'd4;
               par_word_o = {win_i.y_start, win_i.y_end};
            end
            3'd2: begin
               cmd_o      = CMD_RAMWR;
               nparams_o  = 4'd2;
               par_word_o = {win_i.pixel, 16'h0};
            end
            default: cmd_o = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/t08_lcd_sequencer.sv
// LCD command sequencer: walks the init or window+pixel draw table, issuing a
// command strobe then a parameter strobe per step and handshaking on spi_busy.
module t08_lcd_sequencer
   import t08_lcd_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        init_req_i,
   input  logic        draw_req_i,
   input  logic [15:0] x_start_i,
   input  logic [15:0] x_end_i,
   input  logic [15:0] y_start_i,
   input  logic [15:0] y_end_i,
   input  logic [15:0] pixel_i,
   input  logic        spi_busy_i,
   output logic [31:0] spi_data_o,
   output logic        spi_en_cmd_o,
   output logic        spi_en_par_o,
   output logic        ready_o,
   output logic        done_o
);

   state_e      state_q;
   seq_e        seq_q;
   logic [2:0]  step_q;
   logic [7:0]  tmo_q;
   window_t     win_q;
   logic [31:0] par_word_q;
   logic [31:0] spi_data_q;
   logic        en_cmd_q;
   logic        en_par_q;
   logic        ready_q;
   logic        done_q;

   window_t     req_win;
   seq_e        rom_seq;
   logic [2:0]  rom_step;
   window_t     rom_win;
   logic [7:0]  rom_cmd;
   logic [3:0]  rom_nparams;
   logic [31:0] rom_par;
   logic [2:0]  step_d;

   assign req_win = '{x_start: x_start_i, x_end: x_end_i,
                      y_start: y_start_i, y_end: y_end_i, pixel: pixel_i};

   // Saturating increment: the step index must never wrap.
   assign step_d = (step_q == 3'd7) ? step_q : step_q + 3'd1;

   // The ROM looks one step ahead so the command strobe can be registered on
   // the same edge that enters SEND_CMD (request in IDLE, or advance in NEXT).
   always_comb begin
      rom_seq  = seq_q;
      rom_step = step_q;
      rom_win  = win_q;
      if (state_q == ST_IDLE) begin
         rom_seq  = init_req_i ? SEQ_INIT : SEQ_DRAW;
         rom_step = 3'd0;
         if (!init_req_i) begin
            rom_win = req_win;
         end
      end else if (state_q == ST_NEXT) begin
         rom_step = step_d;
      end
   end

   t08_lcd_step_rom u_step_rom (
      .seq_i      (rom_seq),
      .step_i     (rom_step),
      .win_i      (rom_win),
      .cmd_o      (rom_cmd),
      .nparams_o  (rom_nparams),
      .par_word_o (rom_par)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ST_IDLE;
         seq_q      <= SEQ_INIT;
         step_q     <= 3'd0;
         tmo_q      <= 8'd0;
         win_q      <= '0;
         par_word_q <= 32'h0;
         spi_data_q <= 32'h0;
         en_cmd_q   <= 1'b0;
         en_par_q   <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         spi_data_q <= 32'h0;
         en_cmd_q   <= 1'b0;
         en_par_q   <= 1'b0;
         done_q     <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (init_req_i || draw_req_i) begin
                  seq_q      <= rom_seq;
                  step_q     <= 3'd0;
                  if (!init_req_i) begin
                     win_q <= req_win;
                  end
                  spi_data_q <= cmd_word(rom_cmd, rom_nparams);
                  en_cmd_q   <= 1'b1;
                  par_word_q <= rom_par;
                  ready_q    <= 1'b0;
                  state_q    <= ST_SEND_CMD;
               end
            end
            ST_SEND_CMD: begin
               spi_data_q <= par_word_q;
               en_par_q   <= 1'b1;
               state_q    <= ST_SEND_PAR;
            end
            ST_SEND_PAR: begin
               tmo_q   <= 8'd0;
               state_q <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (spi_busy_i || (tmo_q == WAIT_HI_LAST)) begin
                  tmo_q   <= 8'd0;
                  state_q <= ST_WAIT_LO;
               end else begin
                  tmo_q <= tmo_q + 8'd1;
               end
            end
            ST_WAIT_LO: begin
               if (!spi_busy_i) begin
                  state_q <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               step_q <= step_d;
               if (step_q == last_step(seq_q)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  spi_data_q <= cmd_word(rom_cmd, rom_nparams);
                  en_cmd_q   <= 1'b1;
                  par_word_q <= rom_par;
                  state_q    <= ST_SEND_CMD;
               end
            end
            ST_FINISH: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_data_o   = spi_data_q;
   assign spi_en_cmd_o = en_cmd_q;
   assign spi_en_par_o = en_par_q;
   assign ready_o      = ready_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_t08_lcd_sequencer.sv
// Directed bench for the LCD sequencer: a small busy-responder plays the SPI
// stage while a monitor logs strobes; expected words are hand-computed.
module tb_t08_lcd_sequencer;

   logic        clk = 1'b0;
   logic        nrst;
   logic        init_req, draw_req;
   logic [15:0] xs, xe, ys, ye, pix;
   logic        spi_busy;
   logic [31:0] spi_data;
   logic        en_cmd, en_par, ready, done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] cmd_log[$];
   logic [31:0] par_log[$];
   int          cmd_cyc[$];
   int          par_cyc[$];
   int          done_cnt;
   bit          busy_en;
   int          busy_left;

   logic [31:0] exp_init_cmd[5] = '{32'h001, 32'h011, 32'h13A, 32'h136, 32'h029};
   logic [31:0] exp_init_par[5] = '{32'h0, 32'h0, 32'h55000000, 32'h48000000, 32'h0};
   logic [31:0] exp_draw_cmd[3] = '{32'h42A, 32'h42B, 32'h22C};
   logic [31:0] exp_draw_par[3] = '{32'h0010001F, 32'h0020002F, 32'hF8000000};

   t08_lcd_sequencer dut (
      .clk          (clk),
      .nrst         (nrst),
      .init_req_i   (init_req),
      .draw_req_i   (draw_req),
      .x_start_i    (xs),
      .x_end_i      (xe),
      .y_start_i    (ys),
      .y_end_i      (ye),
      .pixel_i      (pix),
      .spi_busy_i   (spi_busy),
      .spi_data_o   (spi_data),
      .spi_en_cmd_o (en_cmd),
      .spi_en_par_o (en_par),
      .ready_o      (ready),
      .done_o       (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // SPI stage model: raise busy for 3 cycles after each parameter strobe.
   always @(negedge clk) begin
      if (!busy_en) begin
         spi_busy = 1'b0;
         busy_left = 0;
      end else if (busy_left > 0) begin
         spi_busy = 1'b1;
         busy_left--;
      end else if (en_par) begin
         spi_busy = 1'b1;
         busy_left = 2;
      end else begin
         spi_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (en_cmd) begin
         cmd_log.push_back(spi_data);
         cmd_cyc.push_back(cyc);
      end
      if (en_par) begin
         par_log.push_back(spi_data);
         par_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      checks++;
      assert (!(en_cmd && en_par)) else begin
         errors++;
         $error("FAIL strobe_exclusive observed=%0b%0b required=no overlap at cyc %0d", en_cmd, en_par, cyc);
      end
      if (!en_cmd && !en_par) begin
         checks++;
         assert (spi_data === 32'h0) else begin
            errors++;
            $error("FAIL idle_data observed=%08h required=00000000 at cyc %0d", spi_data, cyc);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h required=%08h", tag, obs, exp);
      end
      $display("check %-26s observed=%08h required=%08h", tag, obs, exp);
   endtask

   task automatic clear_logs();
      cmd_log.delete();
      par_log.delete();
      cmd_cyc.delete();
      par_cyc.delete();
      done_cnt = 0;
   endtask

   // Request held across exactly one rising edge; returns on the following
   // falling edge, where the first command strobe is already visible.
   task automatic pulse(input logic i, input logic d);
      @(negedge clk);
      init_req = i;
      draw_req = d;
      @(posedge clk);
      @(negedge clk);
      init_req = 1'b0;
      draw_req = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int bad_ready = 0;
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (ready) bad_ready++;
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " ready_low"}, 32'(bad_ready), 32'd0);
      @(negedge clk);
      chk({tag, " done_1cyc"}, 32'(done), 32'd0);
      chk({tag, " ready_back"}, 32'(ready), 32'd1);
      chk({tag, " done_count"}, 32'(done_cnt), 32'd1);
   endtask

   function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEADBEEF;
   endfunction

   task automatic check_init(input string tag);
      chk({tag, " ncmd"}, 32'(cmd_log.size()), 32'd5);
      chk({tag, " npar"}, 32'(par_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("%s cmd%0d", tag, i), log_at(cmd_log, i), exp_init_cmd[i]);
         chk($sformatf("%s par%0d", tag, i), log_at(par_log, i), exp_init_par[i]);
      end
   endtask

   task automatic check_draw(input string tag);
      chk({tag, " ncmd"}, 32'(cmd_log.size()), 32'd3);
      chk({tag, " npar"}, 32'(par_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s cmd%0d", tag, i), log_at(cmd_log, i), exp_draw_cmd[i]);
         chk($sformatf("%s par%0d", tag, i), log_at(par_log, i), exp_draw_par[i]);
      end
   endtask

   initial begin
      bit found;
      nrst = 1'b0;
      init_req = 1'b0;
      draw_req = 1'b0;
      xs = 16'h0; xe = 16'h0; ys = 16'h0; ye = 16'h0; pix = 16'h0;
      spi_busy = 1'b0;
      busy_en = 1'b1;
      busy_left = 0;
      done_cnt = 0;
      repeat (3) @(negedge clk);
      chk("rst spi_data", spi_data, 32'h0);
      chk("rst en_cmd", 32'(en_cmd), 32'd0);
      chk("rst en_par", 32'(en_par), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst ready", 32'(ready), 32'd1);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // Init sequence with 3-cycle busy responder.
      clear_logs();
      pulse(1'b1, 1'b0);
      chk("init latency en_cmd", 32'(en_cmd), 32'd1);
      chk("init first word", spi_data, 32'h001);
      wait_done(300, "init");
      check_init("init");

      // Draw sequence.
      xs = 16'h0010; xe = 16'h001F; ys = 16'h0020; ye = 16'h002F; pix = 16'hF800;
      clear_logs();
      pulse(1'b0, 1'b1);
      chk("draw latency en_cmd", 32'(en_cmd), 32'd1);
      wait_done(300, "draw");
      check_draw("draw");

      // Simultaneous requests: init wins.
      xs = 16'h1111; xe = 16'h2222; ys = 16'h3333; ye = 16'h4444; pix = 16'h07E0;
      clear_logs();
      pulse(1'b1, 1'b1);
      wait_done(300, "both");
      check_init("both");

      // Draw request mid-init is ignored.
      clear_logs();
      pulse(1'b1, 1'b0);
      repeat (6) @(negedge clk);
      chk("midinit ready", 32'(ready), 32'd0);
      pulse(1'b0, 1'b1);
      wait_done(300, "midinit");
      check_init("midinit");
      repeat (5) @(negedge clk);
      chk("midinit no_extra_cmd", 32'(cmd_log.size()), 32'd5);

      // No busy at all: every step leaves WAIT_HI on the 255-cycle timeout.
      xs = 16'h0010; xe = 16'h001F; ys = 16'h0020; ye = 16'h002F; pix = 16'hF800;
      busy_en = 1'b0;
      clear_logs();
      pulse(1'b0, 1'b1);
      wait_done(1500, "timeout");
      check_draw("timeout");
      if (cmd_cyc.size() == 3 && par_cyc.size() == 3) begin
         chk("timeout gap0", 32'(cmd_cyc[1] - par_cyc[0]), 32'd258);
         chk("timeout gap1", 32'(cmd_cyc[2] - par_cyc[1]), 32'd258);
      end else begin
         chk("timeout strobe_count", 32'(cmd_cyc.size()), 32'd3);
      end
      busy_en = 1'b1;
      repeat (2) @(negedge clk);

      // Reset while WAIT_LO of step 2.
      clear_logs();
      pulse(1'b1, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         @(negedge clk);
         if (par_log.size() >= 3) found = 1'b1;
      end
      chk("rstmid reached_step2", 32'(found), 32'd1);
      repeat (2) @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("rstmid spi_data", spi_data, 32'h0);
      chk("rstmid en_cmd", 32'(en_cmd), 32'd0);
      chk("rstmid en_par", 32'(en_par), 32'd0);
      chk("rstmid done", 32'(done), 32'd0);
      chk("rstmid ready", 32'(ready), 32'd1);
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      repeat (30) @(negedge clk);
      chk("rstmid ncmd", 32'(cmd_log.size()), 32'd3);
      chk("rstmid npar", 32'(par_log.size()), 32'd3);
      chk("rstmid done_count", 32'(done_cnt), 32'd0);
      chk("rstmid ready_after", 32'(ready), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
